// File: rtl/bcd_digit_accumulator.sv
// Decimal digit entry to binary: value <= value*10 + digit via a 3-cycle shift-add FSM.
// Optional macro SCORE_SATURATE_EN clamps value to all-ones on overflow instead of wrapping.
module bcd_digit_accumulator #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output logic             digit_ready,
    output logic [WIDTH-1:0] value,
    output logic [2:0]       count,
    output logic             full,
    output logic             busy,
    output logic             bad_digit,
    output logic             overflow
);

    localparam int         AW        = WIDTH + 4;
    localparam logic [2:0] MAX_COUNT = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_X8   = 2'd1,
        S_X2   = 2'd2,
        S_ADD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [2:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              bad_q, bad_d;
    logic [3:0]        digit_q, digit_d;
    logic [AW-1:0]     acc_q, acc_d;

    logic              full_s;
    logic              transfer_s;
    logic [AW-1:0]     sum_s;

    assign full_s     = (count_q == MAX_COUNT);
    assign transfer_s = (state_q == S_IDLE) && !full_s && digit_valid;
    assign sum_s      = acc_q + AW'(digit_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear aborts any operation in flight
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (transfer_s && (digit <= 4'd9)) begin
                        state_d = S_X8;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_X8:    state_d = S_X2;
                S_X2:    state_d = S_ADD;
                S_ADD:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next-state: x8, then +x2, then +digit with overflow detection
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        bad_d   = 1'b0;
        digit_d = digit_q;
        acc_d   = acc_q;
        if (clear) begin
            value_d = '0;
            count_d = 3'd0;
            ovf_d   = 1'b0;
            digit_d = 4'd0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (transfer_s) begin
                        if (digit <= 4'd9) begin
                            digit_d = digit;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end else begin
                        digit_d = digit_q;
                    end
                end
                S_X8: acc_d = AW'(value_q) << 3;
                S_X2: acc_d = acc_q + (AW'(value_q) << 1);
                S_ADD: begin
                    count_d = count_q + 3'd1;
                    if (sum_s[AW-1:WIDTH] != 4'd0) begin
                        ovf_d = 1'b1;
`ifdef SCORE_SATURATE_EN
                        value_d = {WIDTH{1'b1}};
`else
                        value_d = sum_s[WIDTH-1:0];
`endif
                    end else begin
                        value_d = sum_s[WIDTH-1:0];
                    end
                end
                default: acc_d = acc_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
            digit_q <= 4'd0;
            acc_q   <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
            digit_q <= digit_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs decoded only from registers
    always_comb begin
        digit_ready = (state_q == S_IDLE) && !full_s;
        busy        = (state_q != S_IDLE);
        full        = full_s;
        value       = value_q;
        count       = count_q;
        bad_digit   = bad_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Randomized scoreboard bench for bcd_digit_accumulator (WIDTH=8, MAX_DIGITS=3).
// The reference model tracks the entered number arithmetically; a monitor checks each completed operation.
module tb_bcd_digit_accumulator;

    localparam int W   = 8;
    localparam int MAX = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic         digit_valid = 1'b0;
    logic [3:0]   digit = 4'd0;
    logic         digit_ready;
    logic [W-1:0] value;
    logic [2:0]   count;
    logic         full, busy, bad_digit, overflow;

    bcd_digit_accumulator #(.WIDTH(W), .MAX_DIGITS(MAX)) dut (
        .clk(clk), .reset(reset), .clear(clear), .digit_valid(digit_valid),
        .digit(digit), .digit_ready(digit_ready), .value(value), .count(count),
        .full(full), .busy(busy), .bad_digit(bad_digit), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_bad;
        int val;
        int cnt;
        bit ov;
        bit fl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_val = 0;
    int m_cnt = 0;
    bit m_ov  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0;
        m_cnt = 0;
        m_ov  = 1'b0;
    endtask

    task automatic model_accept(input int d);
        int t;
        t = m_val * 10 + d;
        if (t > (1 << W) - 1) begin
            m_ov = 1'b1;
`ifdef SCORE_SATURATE_EN
            m_val = (1 << W) - 1;
`else
            m_val = t % (1 << W);
`endif
        end else begin
            m_val = t;
        end
        m_cnt++;
    endtask

    task automatic push_exp(input bit is_bad);
        exp_t e;
        e.is_bad = is_bad;
        e.val    = m_val;
        e.cnt    = m_cnt;
        e.ov     = m_ov;
        e.fl     = (m_cnt == MAX);
        q.push_back(e);
    endtask

    // Monitor: a completed operation is busy falling; a rejected digit is a bad_digit pulse
    bit prev_busy = 1'b0;
    bit prev_bad  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bad_digit === 1'b1) begin
            check("bad_pulse_single", prev_bad, 1'b0);
            if (q.size() == 0) begin
                check("unexpected_bad_event", 1, 0);
            end else begin
                e = q.pop_front();
                check("bad_kind", 1, e.is_bad);
                check("bad_value", value, e.val);
                check("bad_count", count, e.cnt);
            end
        end
        if (prev_busy && busy === 1'b0) begin
            if (q.size() == 0) begin
                check("unexpected_done_event", 1, 0);
            end else begin
                e = q.pop_front();
                check("done_kind", 0, e.is_bad);
                check("done_value", value, e.val);
                check("done_count", count, e.cnt);
                check("done_overflow", overflow, e.ov);
                check("done_full", full, e.fl);
            end
        end
        prev_busy <= (busy === 1'b1);
        prev_bad  <= (bad_digit === 1'b1);
    end

    // Offer one digit while idle; clr_at 1..3 aborts in X8/X2/ADD using clear or reset
    task automatic do_digit(input logic [3:0] d, input int clr_at, input bit use_rst);
        bit acc_ok;
        bit aborted;
        acc_ok  = (m_cnt < MAX);
        aborted = 1'b0;
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        check("ready_on_offer", digit_ready, acc_ok);
        if (acc_ok) begin
            if (d > 4'd9) begin
                push_exp(1'b1);
            end else if (clr_at == 0) begin
                model_accept(int'(d));
                push_exp(1'b0);
            end
        end
        @(negedge clk);
        digit_valid = 1'b0;
        digit       = 4'($urandom_range(0, 15));
        if (!acc_ok) begin
            check("value_when_full", value, m_val);
        end else if (d > 4'd9) begin
            check("ready_after_bad", digit_ready, 1'b1);
            @(negedge clk);
            check("bad_low_after_pulse", bad_digit, 1'b0);
        end else begin
            for (int k = 1; k <= 3; k++) begin
                check("ready_low_busy", digit_ready, 1'b0);
                check("busy_high", busy, 1'b1);
                if (clr_at == k) begin
                    model_reset();
                    push_exp(1'b0);
                    if (use_rst) reset = 1'b1;
                    else clear = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    clear = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                if (k < 3) @(negedge clk);
            end
            if (!aborted) @(negedge clk);
            check("ready_after_op", digit_ready, (m_cnt < MAX));
        end
    endtask

    task automatic offer_full(input logic [3:0] d);
        @(negedge clk);
        digit_valid = 1'b1;
        digit       = d;
        check("ready_low_full", digit_ready, 1'b0);
        @(negedge clk);
        digit_valid = 1'b0;
        check("full_value_held", value, m_val);
        check("full_no_bad", bad_digit, 1'b0);
        check("full_busy_low", busy, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_value"}, value, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bad"}, bad_digit, 0);
        check({tag, "_ready"}, digit_ready, 1);
    endtask

    // Clear (optionally with a simultaneous digit offer, which must be dropped) or reset while idle
    task automatic do_clear(input bit with_digit, input bit use_rst);
        @(negedge clk);
        if (use_rst) reset = 1'b1;
        else clear = 1'b1;
        digit_valid = with_digit;
        digit       = 4'($urandom_range(0, 9));
        model_reset();
        @(negedge clk);
        reset       = 1'b0;
        clear       = 1'b0;
        digit_valid = 1'b0;
        check_cleared(use_rst ? "reset" : "clear");
        @(negedge clk);
        check("drop_busy_low", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_cleared("por");

        do_digit(4'd4, 0, 0);
        do_digit(4'd2, 0, 0);

        do_clear(1'b0, 1'b0);
        do_digit(4'd2, 0, 0);
        do_digit(4'd5, 0, 0);
        do_digit(4'd5, 0, 0);
        offer_full(4'd7);

        do_clear(1'b0, 1'b0);
        do_digit(4'd2, 0, 0);
        do_digit(4'd5, 0, 0);
        do_digit(4'd6, 0, 0);

        do_clear(1'b0, 1'b0);
        do_digit(4'd3, 0, 0);
        do_digit(4'hC, 0, 0);

        do_clear(1'b0, 1'b0);
        do_digit(4'd4, 0, 0);
        do_digit(4'd2, 0, 0);
        do_digit(4'd5, 2, 0);
        do_digit(4'd7, 0, 0);
        do_clear(1'b1, 1'b0);

        do_digit(4'd9, 0, 0);
        do_digit(4'd9, 0, 0);
        do_digit(4'd9, 0, 0);
        do_clear(1'b0, 1'b1);
        do_digit(4'd1, 0, 0);
        do_digit(4'd5, 1, 1);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (m_cnt == MAX) begin
                if (r < 5) offer_full(4'($urandom_range(0, 15)));
                else do_clear(r[0], r == 9);
            end else if (r == 0) begin
                do_digit(4'($urandom_range(10, 15)), 0, 0);
            end else if (r == 1) begin
                do_digit(4'($urandom_range(0, 9)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            end else if (r == 2) begin
                do_clear(1'b1, 1'b0);
            end else begin
                do_digit(4'($urandom_range(0, 9)), 0, 0);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
